ex_alu_unit: RTL and testbench

Execute-stage ALU that consumes the 5-bit operation code produced by the ALU control unit together with the two 32-bit operands. It returns a registered result and a branch-taken flag through a valid/ready handshake. Shifts run iteratively, one bit per cycle; all other operations complete in one cycle. The block sits between decode/operand-select and the memory/writeback stage of the core.

---
 rtl/alu_pkg.sv | 52 +++++
 rtl/serial_shifter.sv | 64 ++++++
 rtl/ex_alu_unit.sv | 146 ++++++++++++++
 tb/tb_ex_alu_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : alu_pkg
// Purpose : Operation codes, FSM states and shifter modes shared by the
//           ALU control unit and the execute-stage ALU.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CTRL_W   = 5;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 5'd0;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 5'd1;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 5'd2;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 5'd3;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 5'd4;
  localparam logic [CTRL_W-1:0] ALU_LINK = 5'd5;
  localparam logic [CTRL_W-1:0] ALU_LUI  = 5'd6;
  localparam logic [CTRL_W-1:0] ALU_BGE  = 5'd7;
  localparam logic [CTRL_W-1:0] ALU_BNE  = 5'd8;
  localparam logic [CTRL_W-1:0] ALU_OR   = 5'd9;
  localparam logic [CTRL_W-1:0] ALU_AND  = 5'd10;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 5'd11;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 5'd12;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 5'd13;
  localparam logic [CTRL_W-1:0] ALU_BEQ  = 5'd14;
  localparam logic [CTRL_W-1:0] ALU_BLT  = 5'd15;
  localparam logic [CTRL_W-1:0] ALU_BLTU = 5'd16;
  localparam logic [CTRL_W-1:0] ALU_BGEU = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2
  } shift_mode_e;

  function automatic logic is_branch(input logic [CTRL_W-1:0] code);
    return (code == ALU_BEQ) || (code == ALU_BNE) || (code == ALU_BLT) ||
           (code == ALU_BGE) || (code == ALU_BLTU) || (code == ALU_BGEU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_shifter.sv
// ============================================================================
// Module  : serial_shifter
// Purpose : Iterative shifter moving the working value one bit per cycle.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module serial_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            i_start,
  input  logic            i_clear,
  input  logic [4:0]      i_shamt,
  input  shift_mode_e     i_mode,
  input  logic [XLEN-1:0] i_data,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_value
);

  logic [XLEN-1:0] r_value;
  logic [4:0]      r_cnt;
  shift_mode_e     r_mode;
  logic [XLEN-1:0] w_step;

  always_comb begin
    w_step = r_value;
    case (r_mode)
      SH_SLL:  w_step = {r_value[XLEN-2:0], 1'b0};
      SH_SRL:  w_step = {1'b0, r_value[XLEN-1:1]};
      SH_SRA:  w_step = {r_value[XLEN-1], r_value[XLEN-1:1]};
      default: w_step = r_value;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_value <= '0;
      r_cnt   <= '0;
      r_mode  <= SH_SLL;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_value <= i_data;
      r_cnt   <= i_shamt;
      r_mode  <= i_mode;
    end else if (r_cnt != 5'd0) begin
      r_value <= w_step;
      r_cnt   <= r_cnt - 5'd1;
    end
  end

  // o_value is the value after this cycle's step, so the final bit is visible with o_done
  assign o_busy  = (r_cnt != 5'd0);
  assign o_done  = (r_cnt == 5'd1);
  assign o_value = w_step;

endmodule

`default_nettype wire

// File: rtl/ex_alu_unit.sv
// ============================================================================
// Module  : ex_alu_unit
// Purpose : Execute-stage ALU with valid/ready handshake and serial shifts.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ex_alu_unit
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] alu_ctrl_i,
  input  logic [XLEN-1:0]   op_a_i,
  input  logic [XLEN-1:0]   op_b_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   result_o,
  output logic              branch_taken_o
);

  alu_state_e      r_state;
  logic            w_accept;
  logic            w_is_shift;
  logic            w_start_shift;
  logic            w_cond;
  logic [XLEN-1:0] w_result;
  logic            w_branch;
  shift_mode_e     w_mode;
  logic            w_sh_busy;
  logic            w_sh_done;
  logic [XLEN-1:0] w_sh_value;
  logic            w_lt;
  logic            w_ltu;
  logic            w_eq;

  assign ready_o       = (r_state == ST_IDLE) || ((r_state == ST_DONE) && ready_i);
  assign w_accept      = valid_i && ready_o && !flush_i;
  assign w_is_shift    = (alu_ctrl_i == ALU_SLL) || (alu_ctrl_i == ALU_SRL) ||
                         (alu_ctrl_i == ALU_SRA);
  assign w_start_shift = w_accept && w_is_shift && (op_b_i[4:0] != 5'd0);

  assign w_lt  = $signed(op_a_i) < $signed(op_b_i);
  assign w_ltu = op_a_i < op_b_i;
  assign w_eq  = op_a_i == op_b_i;

  always_comb begin
    w_mode = SH_SRA;
    if (alu_ctrl_i == ALU_SLL)      w_mode = SH_SLL;
    else if (alu_ctrl_i == ALU_SRL) w_mode = SH_SRL;
  end

  // Shift codes only reach this path with shamt 0, where the result is op_a unchanged
  always_comb begin
    w_cond   = 1'b0;
    w_result = '0;
    case (alu_ctrl_i)
      ALU_ADD:  w_result = op_a_i + op_b_i;
      ALU_SUB:  w_result = op_a_i - op_b_i;
      ALU_XOR:  w_result = op_a_i ^ op_b_i;
      ALU_OR:   w_result = op_a_i | op_b_i;
      ALU_AND:  w_result = op_a_i & op_b_i;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  w_result = op_a_i;
      ALU_LINK: w_result = op_a_i + XLEN'(4);
      ALU_LUI:  w_result = op_b_i;
      ALU_SLT,
      ALU_BLT:  w_cond = w_lt;
      ALU_SLTU,
      ALU_BLTU: w_cond = w_ltu;
      ALU_BGE:  w_cond = !w_lt;
      ALU_BGEU: w_cond = !w_ltu;
      ALU_BEQ:  w_cond = w_eq;
      ALU_BNE:  w_cond = !w_eq;
      default:  w_result = '0;
    endcase
    if (w_cond) w_result = {{(XLEN-1){1'b0}}, 1'b1};
  end

  assign w_branch = is_branch(alu_ctrl_i) && w_cond;

  serial_shifter #(.XLEN(XLEN)) u_shifter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_start (w_start_shift),
    .i_clear (flush_i),
    .i_shamt (op_b_i[4:0]),
    .i_mode  (w_mode),
    .i_data  (op_a_i),
    .o_busy  (w_sh_busy),
    .o_done  (w_sh_done),
    .o_value (w_sh_value)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      valid_o        <= 1'b0;
      result_o       <= '0;
      branch_taken_o <= 1'b0;
    end else if (flush_i) begin
      r_state <= ST_IDLE;
      valid_o <= 1'b0;
    end else begin
      case (r_state)
        ST_SHIFT: begin
          if (w_sh_done) begin
            r_state        <= ST_DONE;
            valid_o        <= 1'b1;
            result_o       <= w_sh_value;
            branch_taken_o <= 1'b0;
          end else if (!w_sh_busy) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE, ST_DONE: begin
          if (w_start_shift) begin
            r_state <= ST_SHIFT;
            valid_o <= 1'b0;
          end else if (w_accept) begin
            r_state        <= ST_DONE;
            valid_o        <= 1'b1;
            result_o       <= w_result;
            branch_taken_o <= w_branch;
          end else if (r_state == ST_DONE && ready_i) begin
            r_state <= ST_IDLE;
            valid_o <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_alu_unit.sv
// ============================================================================
// Module  : tb_ex_alu_unit
// Purpose : Directed self-checking bench for ex_alu_unit.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ex_alu_unit;
  import alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [4:0]  alu_ctrl_i = '0;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        flush_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;
  logic        branch_taken_o;

  int checks = 0;
  int errors = 0;

  ex_alu_unit #(.XLEN(32)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .alu_ctrl_i     (alu_ctrl_i),
    .op_a_i         (op_a_i),
    .op_b_i         (op_b_i),
    .flush_i        (flush_i),
    .valid_o        (valid_o),
    .ready_i        (ready_i),
    .result_o       (result_o),
    .branch_taken_o (branch_taken_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
    valid_i    = 1'b1;
    alu_ctrl_i = code;
    op_a_i     = a;
    op_b_i     = b;
  endtask

  initial begin
    int cycles;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      valid_i    = 1'($urandom);
      alu_ctrl_i = 5'($urandom);
      op_a_i     = $urandom;
      op_b_i     = $urandom;
      ready_i    = 1'($urandom);
      step();
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_result", result_o, 32'd0);
    end
    check("rst_branch", {31'b0, branch_taken_o}, 32'd0);
    valid_i = 1'b0;
    ready_i = 1'b1;
    rst_ni  = 1'b1;
    #1;
    check("rst_ready", {31'b0, ready_o}, 32'd1);

    // Back-to-back single-cycle ops
    drive(ALU_ADD, 32'd5, 32'd7);
    step();
    check("add_valid", {31'b0, valid_o}, 32'd1);
    check("add_result", result_o, 32'd12);
    drive(ALU_SUB, 32'd0, 32'd1);
    step();
    check("sub_result", result_o, 32'hFFFF_FFFF);
    drive(ALU_LUI, 32'hDEAD_BEEF, 32'h1234_5000);
    step();
    check("lui_result", result_o, 32'h1234_5000);
    drive(ALU_LINK, 32'h0000_1000, 32'd0);
    step();
    check("link_result", result_o, 32'h0000_1004);
    drive(5'd20, 32'd3, 32'd3);
    step();
    check("undef_result", result_o, 32'd0);
    check("undef_branch", {31'b0, branch_taken_o}, 32'd0);
    valid_i = 1'b0;
    step();
    check("idle_valid", {31'b0, valid_o}, 32'd0);

    // sra 0x80000000 by 4: valid after 5 cycles
    drive(ALU_SRA, 32'h8000_0000, 32'd4);
    for (int i = 1; i <= 4; i++) begin
      step();
      valid_i = 1'b0;
      op_a_i  = 32'h0;
      check("sra_busy_valid", {31'b0, valid_o}, 32'd0);
      check("sra_busy_ready", {31'b0, ready_o}, 32'd0);
    end
    step();
    check("sra_valid", {31'b0, valid_o}, 32'd1);
    check("sra_result", result_o, 32'hF800_0000);

    // sll by 0 completes in one cycle
    drive(ALU_SLL, 32'h0000_ABCD, 32'd0);
    step();
    check("sll0_valid", {31'b0, valid_o}, 32'd1);
    check("sll0_result", result_o, 32'h0000_ABCD);

    // srl 0xFFFFFFFF by 31: latency 32
    drive(ALU_SRL, 32'hFFFF_FFFF, 32'd31);
    cycles = 0;
    do begin
      step();
      valid_i = 1'b0;
      cycles++;
    end while (!valid_o && cycles < 40);
    check("srl31_latency", cycles, 32'd32);
    check("srl31_result", result_o, 32'h0000_0001);

    // Branches and compares
    drive(ALU_BLT, 32'hFFFF_FFFF, 32'd1);
    step();
    check("blt_branch", {31'b0, branch_taken_o}, 32'd1);
    check("blt_result", result_o, 32'd1);
    drive(ALU_BLTU, 32'hFFFF_FFFF, 32'd1);
    step();
    check("bltu_branch", {31'b0, branch_taken_o}, 32'd0);
    check("bltu_result", result_o, 32'd0);
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    step();
    check("slt_result", result_o, 32'd1);
    check("slt_branch", {31'b0, branch_taken_o}, 32'd0);
    drive(ALU_BGE, 32'd7, 32'hFFFF_FFF0);
    step();
    check("bge_branch", {31'b0, branch_taken_o}, 32'd1);

    // Backpressure after xor
    drive(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0);
    step();
    check("xor_result", result_o, 32'h0000_FF00);
    ready_i = 1'b0;
    valid_i = 1'b1;
    alu_ctrl_i = ALU_ADD;
    for (int i = 0; i < 3; i++) begin
      op_a_i = $urandom;
      #1;
      check("bp_ready", {31'b0, ready_o}, 32'd0);
      step();
      check("bp_valid", {31'b0, valid_o}, 32'd1);
      check("bp_result", result_o, 32'h0000_FF00);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    #1;
    check("bp_release_ready", {31'b0, ready_o}, 32'd1);
    step();
    check("bp_drain_valid", {31'b0, valid_o}, 32'd0);

    // Flush at the 3rd cycle of a 10-bit shift, with an add presented
    drive(ALU_SLL, 32'd1, 32'd10);
    step();
    valid_i = 1'b0;
    step();
    flush_i = 1'b1;
    drive(ALU_ADD, 32'd1, 32'd1);
    step();
    flush_i = 1'b0;
    valid_i = 1'b0;
    check("flush_valid", {31'b0, valid_o}, 32'd0);
    check("flush_ready", {31'b0, ready_o}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      step();
      check("flush_quiet", {31'b0, valid_o}, 32'd0);
    end
    drive(ALU_ADD, 32'd100, 32'd23);
    step();
    valid_i = 1'b0;
    check("post_flush_valid", {31'b0, valid_o}, 32'd1);
    check("post_flush_add", result_o, 32'd123);

    // Reset asserted mid-shift
    drive(ALU_SRA, 32'h8000_0000, 32'd8);
    step();
    valid_i = 1'b0;
    step();
    rst_ni = 1'b0;
    #1;
    check("midrst_result", result_o, 32'd0);
    check("midrst_valid", {31'b0, valid_o}, 32'd0);
    check("midrst_ready", {31'b0, ready_o}, 32'd1);
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("midrst_quiet", {31'b0, valid_o}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
